// File: rtl/adder16.sv
// adder16: 16-bit ripple-carry adder with signed overflow flag
// and a registered copy of sum, carry and overflow.
module adder16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        ovf,
    output logic [15:0] s_q,
    output logic        cout_q,
    output logic        ovf_q
);

    logic [16:0] w_c;
    logic [15:0] w_s;
    logic        w_ovf;

    logic [15:0] r_s_q;
    logic        r_cout_q;
    logic        r_ovf_q;

    assign w_c[0] = cin;

    // One full adder per bit; the carry ripples from bit 0 up to bit 15.
    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i])
                        | (a[i] & w_c[i])
                        | (b[i] & w_c[i]);
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign w_ovf = w_c[16] ^ w_c[15];

    assign s    = w_s;
    assign cout = w_c[16];
    assign ovf  = w_ovf;

    // Registered copy; cleared asynchronously while reset is held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q    <= 16'h0000;
            r_cout_q <= 1'b0;
            r_ovf_q  <= 1'b0;
        end else begin
            r_s_q    <= w_s;
            r_cout_q <= w_c[16];
            r_ovf_q  <= w_ovf;
        end
    end

    assign s_q    = r_s_q;
    assign cout_q = r_cout_q;
    assign ovf_q  = r_ovf_q;

endmodule

// File: tb/tb_adder16.sv
// tb_adder16: directed vector table, reset sequences and random
// arithmetic checks for adder16.
module tb_adder16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic [15:0] s_q;
    logic        cout_q;
    logic        ovf_q;

    int errors;
    int checks;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vt[9];

    adder16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .s      (s),
        .cout   (cout),
        .ovf    (ovf),
        .s_q    (s_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [16:0] m_sum;
        logic        m_ovf;

        errors = 0;
        checks = 0;

        vt[0] = '{16'hffff, 16'h0c45, 1'b0, 16'h0c44, 1'b1, 1'b0};
        vt[1] = '{16'hfc43, 16'h0983, 1'b1, 16'h05c7, 1'b1, 1'b0};
        vt[2] = '{16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[4] = '{16'hffff, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vt[6] = '{16'hffff, 16'hffff, 1'b1, 16'hffff, 1'b1, 1'b0};
        vt[7] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[8] = '{16'h8000, 16'hffff, 1'b0, 16'h7fff, 1'b1, 1'b1};

        rst_n = 1'b1;
        a     = 16'h7fff;
        b     = 16'h0001;
        cin   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_s_q", 32'(s_q), 32'h0);
        chk("rst_cout_q", 32'(cout_q), 32'h0);
        chk("rst_ovf_q", 32'(ovf_q), 32'h0);
        chk("rst_comb_s", 32'(s), 32'h8000);
        chk("rst_comb_ovf", 32'(ovf), 32'h1);

        @(posedge clk);
        #1;
        chk("rst_hold_s_q", 32'(s_q), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_s_q", 32'(s_q), 32'h8000);
        chk("rel_ovf_q", 32'(ovf_q), 32'h1);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a   = vt[i].a;
            b   = vt[i].b;
            cin = vt[i].cin;
            #1;
            chk($sformatf("v%0d_s", i), 32'(s), 32'(vt[i].s));
            chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vt[i].cout));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].ovf));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_s_q", i), 32'(s_q), 32'(vt[i].s));
            chk($sformatf("v%0d_cout_q", i), 32'(cout_q),
                32'(vt[i].cout));
            chk($sformatf("v%0d_ovf_q", i), 32'(ovf_q), 32'(vt[i].ovf));
        end

        @(negedge clk);
        a   = 16'hfc43;
        b   = 16'h0983;
        cin = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_pre_s_q", 32'(s_q), 32'h05c7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_s_q", 32'(s_q), 32'h0);
        chk("mid_cout_q", 32'(cout_q), 32'h0);
        chk("mid_ovf_q", 32'(ovf_q), 32'h0);
        chk("mid_comb_s", 32'(s), 32'h05c7);
        chk("mid_comb_cout", 32'(cout), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_wait_s_q", 32'(s_q), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rel_s_q", 32'(s_q), 32'h05c7);
        chk("mid_rel_cout_q", 32'(cout_q), 32'h1);

        for (int i = 0; i < 10000; i++) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            cin   = 1'($urandom);
            m_sum = 17'(a) + 17'(b) + 17'(cin);
            m_ovf = (a[15] == b[15]) && (m_sum[15] != a[15]);
            #1;
            checks++;
            if ({cout, s} !== m_sum || ovf !== m_ovf) begin
                errors++;
                $display("FAIL rnd%0d: a=%h b=%h cin=%b got %h/%b expected %h/%b",
                         i, a, b, cin, {cout, s}, ovf, m_sum, m_ovf);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder16.md
ADDER16 -- requirements
Module: adder16

Interface
REQ-001 Parameters: none; the datapath width SHALL be fixed at 16 bits.
REQ-002 clk  input  1  rising-edge clock for the registered result copy only.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a  input  16  unsigned/two's-complement addend A.
REQ-005 b  input  16  addend B.
REQ-006 cin  input  1  carry into bit 0.
REQ-007 s  output  16  combinational sum bits [15:0].
REQ-008 cout  output  1  combinational carry out of bit 15.
REQ-009 s_q  output  16  registered copy of s.
REQ-010 cout_q  output  1  registered copy of cout.
REQ-011 ovf  output  1  combinational signed overflow flag.
REQ-012 ovf_q  output  1  registered copy of ovf.
REQ-013 Ports a, b, cin, s and cout SHALL also be usable alone, by name, with the remaining outputs unconnected.

Function
REQ-014 {cout, s} SHALL equal a + b + cin, computed modulo 2^17 with no saturation.
REQ-015 The adder SHALL be a ripple-carry chain of 16 one-bit full adders.
  - Bit i: s[i] = a[i] ^ b[i] ^ c[i].
  - Bit i: c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - c[0] = cin; cout = c[16].
REQ-016 s, cout and ovf SHALL be purely combinational: zero clock latency, valid one settling delay after any change of a, b or cin.
REQ-017 s, cout and ovf SHALL be independent of clk and rst_n, including while rst_n is low.
REQ-018 ovf SHALL equal c[16] ^ c[15] (signed overflow).
  - ovf = 1 when a[15] == b[15] and s[15] != a[15].
REQ-019 On each rising clk edge with rst_n high, s_q, cout_q and ovf_q SHALL load s, cout and ovf.
  - Latency to the registered outputs is 1 cycle.
REQ-020 Every input value SHALL be legal, with no unknown-propagation special cases.
  - Carry-in with all-ones operands wraps correctly, e.g. ffff+ffff+1 -> s=ffff, cout=1.
REQ-021 The block SHALL contain no other state; there is no handshake or enable.

Reset
REQ-022 While rst_n is low, s_q, cout_q and ovf_q SHALL be 0 immediately, without waiting for a clock edge.
REQ-023 On reset deassertion, the first rising clk edge SHALL load the current combinational result.
REQ-024 Reset asserted mid-operation SHALL clear the registered outputs asynchronously and leave s, cout and ovf unaffected.

Verification
REQ-025 a=ffff, b=0c45, cin=0 -> s=0c44, cout=1, ovf=0; after 1 clk: s_q=0c44, cout_q=1.
REQ-026 a=fc43, b=0983, cin=1 -> s=05c7, cout=1, ovf=0.
REQ-027 a=7fff, b=0001, cin=0 -> s=8000, cout=0, ovf=1.
REQ-028 a=8000, b=8000, cin=0 -> s=0000, cout=1, ovf=1.
REQ-029 a=ffff, b=0000, cin=1 -> s=0000, cout=1 (full 16-bit ripple); a=0000, b=0000, cin=1 -> s=0001, cout=0.
REQ-030 Reset check:
  - Load s_q=05c7, then pull rst_n low between clock edges -> s_q=0000, cout_q=0, ovf_q=0 at once, while s stays 05c7.
  - Release rst_n -> s_q=05c7 at the next rising edge.
REQ-031 Random check: at least 10^4 random {a, b, cin} vectors SHALL match the arithmetic {cout, s} = a + b + cin exactly.
